k2_fetch_unit: RTL

- Instruction-fetch stage of the K2 8-bit CPU, directly upstream of the 16-entry instruction memory.
- Owns the 4-bit program counter (PC), drives the memory address and captures the returned 8-bit word into an instruction register.
- Presents the word to the decoder with a valid/ready handshake.
- Accepts branch/jump redirects and a halt request from execute.

---
 rtl/k2_pkg.sv | 9 +
 rtl/k2_sat_counter.sv | 15 +
 rtl/k2_fetch_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/k2_pkg.sv
// k2_pkg: shared widths, types and fetch FSM states for the K2 fetch stage.
// Contents: PC_W/INSTR_W widths, pc_t/instr_t word types, fetch_state_t enum.
package k2_pkg;
    localparam int PC_W    = 4;
    localparam int INSTR_W = 8;
    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef enum logic [1:0] {ISSUE, CAPTURE, VALID, HALT} fetch_state_t;
endpackage

// File: rtl/k2_sat_counter.sv
// k2_sat_counter: saturating up-counter with synchronous clear.
// Ports: clk, clr (sync clear, wins over inc), inc (count enable), cnt (value, sticks at all-ones).
module k2_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/k2_fetch_unit.sv
// k2_fetch_unit: K2 instruction-fetch stage (PC, imem address, instruction register, valid/ready).
// Ports: clk; reset (sync, active-low); imem_addr/imem_data (1-cycle-latency memory);
//        instr/instr_pc/instr_valid/instr_ready (decoder handshake);
//        redir_valid/redir_target (branch redirect); halt_req/halted.
// Build option K2_FETCH_PERF_EN adds fetch_cnt (handshakes) and stall_cnt (stalled VALID cycles).
module k2_fetch_unit
    import k2_pkg::*;
#(
    parameter pc_t RESET_PC = '0
) (
    input  logic   clk,
    input  logic   reset,
    output pc_t    imem_addr,
    input  instr_t imem_data,
    output instr_t instr,
    output pc_t    instr_pc,
    output logic   instr_valid,
    input  logic   instr_ready,
    input  logic   redir_valid,
    input  pc_t    redir_target,
    input  logic   halt_req,
    output logic   halted
`ifdef K2_FETCH_PERF_EN
    ,
    output logic [7:0] fetch_cnt,
    output logic [7:0] stall_cnt
`endif
);
    fetch_state_t state, state_n;
    pc_t pc;

    always_ff @(posedge clk) begin
        if (!reset) state <= ISSUE;
        else state <= state_n;
    end

    // In VALID instr_valid is always 1, so instr_ready alone marks a handshake.
    // Halt beats redirect at a handshake; redirect beats plain acceptance.
    always_comb begin
        state_n = state;
        case (state)
            ISSUE:   state_n = redir_valid ? ISSUE : CAPTURE;
            CAPTURE: state_n = redir_valid ? ISSUE : VALID;
            VALID:   state_n = (instr_ready && halt_req) ? HALT :
                               (instr_ready || redir_valid) ? ISSUE : VALID;
            HALT:    state_n = HALT;
            default: state_n = ISSUE;
        endcase
    end

    // A redirect in CAPTURE drops the in-flight word; PC still takes the target
    // even when the same cycle's handshake sends us to HALT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (state != HALT && redir_valid) pc <= redir_target;
            else if (state == CAPTURE) pc <= pc + 1'b1;
            if (state == CAPTURE && !redir_valid) begin
                instr    <= imem_data;
                instr_pc <= pc;
            end
            instr_valid <= state_n == VALID;
        end
    end

    always_comb begin
        imem_addr = pc;
        halted    = state == HALT;
    end

`ifdef K2_FETCH_PERF_EN
    k2_sat_counter #(.WIDTH(8)) u_fetch_cnt (
        .clk (clk),
        .clr (!reset),
        .inc (state == VALID && instr_ready),
        .cnt (fetch_cnt)
    );
    k2_sat_counter #(.WIDTH(8)) u_stall_cnt (
        .clk (clk),
        .clr (!reset),
        .inc (state == VALID && !instr_ready),
        .cnt (stall_cnt)
    );
`endif
endmodule
